// File: rtl/ise_color_accum_if.sv
// Pixel stream and summary-record bundle for the ISE colour accumulator.
// The master drives pixels and accepts records; the slave is the accumulator.
interface ise_color_accum_if #(
  parameter int unsigned IDX_W = 5
) ();

  logic             in_valid;
  logic [IDX_W-1:0] image_in_index;
  logic [23:0]      pixel_in;
  logic             busy;

  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_index;
  logic [1:0]       res_color;
  logic [7:0]       res_mean;
  logic             idx_err;

  modport master (
    output in_valid, image_in_index, pixel_in, res_ready,
    input  busy, res_valid, res_index, res_color, res_mean, idx_err
  );

  modport slave (
    input  in_valid, image_in_index, pixel_in, res_ready,
    output busy, res_valid, res_index, res_color, res_mean, idx_err
  );

endinterface

// File: rtl/ise_color_accum.sv
// ISE upstream stage: classifies each pixel by its dominant channel, accumulates per-colour
// counts and channel sums, and at each image boundary emits {index, dominant colour, mean}.
module ise_color_accum #(
  parameter int unsigned PIX_PER_IMG = 16384,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned SUM_W       = 22
) (
  input logic             clk,
  input logic             reset,
  ise_color_accum_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(PIX_PER_IMG + 1);
  localparam int unsigned STEP_W = $clog2(SUM_W + 1);

  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(PIX_PER_IMG - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

  // StDom is the one-cycle dominant-colour latch between the last pixel and the divider.
  typedef enum logic [1:0] {StAccum, StDom, StDiv, StOut} state_e;

  state_e            state;
  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  cnt_r, cnt_g, cnt_b;
  logic [SUM_W-1:0]  sum_r, sum_g, sum_b;
  logic [IDX_W-1:0]  cur_idx;
  logic [1:0]        dom;
  logic [SUM_W-1:0]  div_q;
  logic [CNT_W-1:0]  div_rem;
  logic [CNT_W-1:0]  divisor;
  logic [STEP_W-1:0] step;

  logic              res_valid;
  logic [IDX_W-1:0]  res_index;
  logic [1:0]        res_color;
  logic [7:0]        res_mean;
  logic              idx_err;

  logic [7:0]        pix_r, pix_g, pix_b;
  logic [1:0]        pix_cls;
  logic              accept;
  logic [1:0]        dom_sel;
  logic [SUM_W-1:0]  dom_sum;
  logic [CNT_W-1:0]  dom_cnt;
  logic [CNT_W:0]    shifted;
  logic [CNT_W+1:0]  diff;
  logic              ge;
  logic [CNT_W-1:0]  rem_next;
  logic [SUM_W-1:0]  q_next;

  // Classify the incoming pixel; ties resolve toward R, then G.
  always_comb begin
    pix_r  = bus.pixel_in[23:16];
    pix_g  = bus.pixel_in[15:8];
    pix_b  = bus.pixel_in[7:0];
    accept = bus.in_valid && (state == StAccum);
    if (pix_r >= pix_g && pix_r >= pix_b) begin
      pix_cls = 2'd0;
    end else if (pix_g >= pix_b) begin
      pix_cls = 2'd1;
    end else begin
      pix_cls = 2'd2;
    end
  end

  // Pick the dominant colour by pixel count (ties R>G>B) and its divider operands.
  always_comb begin
    if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
      dom_sel = 2'd0;
    end else if (cnt_g >= cnt_b) begin
      dom_sel = 2'd1;
    end else begin
      dom_sel = 2'd2;
    end
    unique case (dom_sel)
      2'd1:    begin dom_sum = sum_g; dom_cnt = cnt_g; end
      2'd2:    begin dom_sum = sum_b; dom_cnt = cnt_b; end
      default: begin dom_sum = sum_r; dom_cnt = cnt_r; end
    endcase
  end

  // One restoring-division step; the remainder always stays below the divisor.
  always_comb begin
    shifted  = {div_rem, div_q[SUM_W-1]};
    diff     = {1'b0, shifted} - {2'b00, divisor};
    ge       = !diff[CNT_W+1];
    rem_next = ge ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
    q_next   = {div_q[SUM_W-2:0], ge};
  end

  // Main FSM: accumulate, latch dominant colour, divide, then hold the record until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StAccum;
      pix_cnt   <= '0;
      cnt_r     <= '0;
      cnt_g     <= '0;
      cnt_b     <= '0;
      sum_r     <= '0;
      sum_g     <= '0;
      sum_b     <= '0;
      cur_idx   <= '0;
      dom       <= '0;
      div_q     <= '0;
      div_rem   <= '0;
      divisor   <= '0;
      step      <= '0;
      res_valid <= 1'b0;
      res_index <= '0;
      res_color <= '0;
      res_mean  <= '0;
      idx_err   <= 1'b0;
    end else begin
      unique case (state)
        StAccum: begin
          if (accept) begin
            pix_cnt <= pix_cnt + 1'b1;
            unique case (pix_cls)
              2'd1: begin
                cnt_g <= cnt_g + 1'b1;
                sum_g <= sum_g + SUM_W'(pix_g);
              end
              2'd2: begin
                cnt_b <= cnt_b + 1'b1;
                sum_b <= sum_b + SUM_W'(pix_b);
              end
              default: begin
                cnt_r <= cnt_r + 1'b1;
                sum_r <= sum_r + SUM_W'(pix_r);
              end
            endcase
            // The first pixel names the image; a later mismatch is flagged but not adopted.
            if (pix_cnt == '0) begin
              cur_idx <= bus.image_in_index;
            end else if (bus.image_in_index != cur_idx) begin
              idx_err <= 1'b1;
            end
            if (pix_cnt == LAST_PIX) begin
              state <= StDom;
            end
          end
        end
        StDom: begin
          dom     <= dom_sel;
          div_q   <= dom_sum;
          divisor <= dom_cnt;
          div_rem <= '0;
          step    <= '0;
          state   <= StDiv;
        end
        StDiv: begin
          div_q   <= q_next;
          div_rem <= rem_next;
          step    <= step + 1'b1;
          if (step == LAST_STEP) begin
            res_valid <= 1'b1;
            res_index <= cur_idx;
            res_color <= dom;
            res_mean  <= q_next[7:0];
            state     <= StOut;
          end
        end
        StOut: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            pix_cnt   <= '0;
            cnt_r     <= '0;
            cnt_g     <= '0;
            cnt_b     <= '0;
            sum_r     <= '0;
            sum_g     <= '0;
            sum_b     <= '0;
            state     <= StAccum;
          end
        end
      endcase
    end
  end

  assign bus.busy      = (state != StAccum);
  assign bus.res_valid = res_valid;
  assign bus.res_index = res_index;
  assign bus.res_color = res_color;
  assign bus.res_mean  = res_mean;
  assign bus.idx_err   = idx_err;

endmodule

// File: tb/tb_ise_color_accum.sv
// Scoreboard bench for ise_color_accum: a 16-pixel and a 4-pixel instance share clock and reset.
module tb_ise_color_accum;

  localparam int unsigned SUM_W = 22;
  localparam int unsigned PIX_A = 16;
  localparam int unsigned PIX_B = 4;

  typedef struct packed {
    logic [4:0] idx;
    logic [1:0] color;
    logic [7:0] mean;
  } rec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ise_color_accum_if #(.IDX_W(5)) a_if ();
  ise_color_accum_if #(.IDX_W(5)) b_if ();

  ise_color_accum #(.PIX_PER_IMG(PIX_A), .IDX_W(5), .SUM_W(SUM_W)) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (a_if)
  );

  ise_color_accum #(.PIX_PER_IMG(PIX_B), .IDX_W(5), .SUM_W(SUM_W)) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b_if)
  );

  rec_t       q_a[$];
  rec_t       q_b[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         m_cnt[2][3];
  int         m_sum[2][3];
  int         m_n[2];
  logic [4:0] m_idx[2];
  logic       m_err[2];
  int         acc_cyc[2];
  logic       a_pv = 1'b0;
  logic       b_pv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? a_if.busy : b_if.busy;
  endfunction

  task automatic model_clear(input int sel);
    for (int c = 0; c < 3; c++) begin
      m_cnt[sel][c] = 0;
      m_sum[sel][c] = 0;
    end
    m_n[sel] = 0;
  endtask

  // Reference classification and per-image record computation.
  task automatic model_accept(input int sel, input logic [4:0] idx, input logic [23:0] px);
    int ch[3];
    int cls;
    int dom;
    rec_t r;
    ch[0] = int'(px[23:16]);
    ch[1] = int'(px[15:8]);
    ch[2] = int'(px[7:0]);
    if (ch[0] >= ch[1] && ch[0] >= ch[2]) cls = 0;
    else if (ch[1] >= ch[2]) cls = 1;
    else cls = 2;
    if (m_n[sel] == 0) m_idx[sel] = idx;
    else if (idx != m_idx[sel]) m_err[sel] = 1'b1;
    m_cnt[sel][cls] += 1;
    m_sum[sel][cls] += ch[cls];
    m_n[sel] += 1;
    if (m_n[sel] == ((sel == 0) ? PIX_A : PIX_B)) begin
      if (m_cnt[sel][0] >= m_cnt[sel][1] && m_cnt[sel][0] >= m_cnt[sel][2]) dom = 0;
      else if (m_cnt[sel][1] >= m_cnt[sel][2]) dom = 1;
      else dom = 2;
      r.idx   = m_idx[sel];
      r.color = 2'(dom);
      r.mean  = 8'((m_sum[sel][dom] / m_cnt[sel][dom]) & 255);
      if (sel == 0) q_a.push_back(r);
      else q_b.push_back(r);
      model_clear(sel);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [4:0] idx,
                       input logic [23:0] px);
    if (sel == 0) begin
      a_if.in_valid = v; a_if.image_in_index = idx; a_if.pixel_in = px;
    end else begin
      b_if.in_valid = v; b_if.image_in_index = idx; b_if.pixel_in = px;
    end
  endtask

  // Present one pixel once the DUT is free; it is accepted on the following rising edge.
  task automatic send(input int sel, input logic [4:0] idx, input logic [23:0] px);
    int g = 0;
    @(negedge clk);
    while (get_busy(sel) && g < 200) begin
      drive(sel, 1'b0, 5'd0, 24'd0);
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      check("send_timeout", 1, 0);
    end else begin
      drive(sel, 1'b1, idx, px);
      acc_cyc[sel] = cyc + 1;
      model_accept(sel, idx, px);
    end
  endtask

  task automatic idle(input int sel);
    @(negedge clk);
    drive(sel, 1'b0, 5'd0, 24'd0);
  endtask

  task automatic drain(input int sel);
    int g = 0;
    while (qsize(sel) != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check((sel == 0) ? "a_drain" : "b_drain", qsize(sel), 0);
  endtask

  // Monitor for the 16-pixel instance: latency on each record, contents on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_if.res_valid && !a_pv) check("a_latency", cyc - acc_cyc[0], SUM_W + 1);
      if (a_if.res_valid && a_if.res_ready) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_record", 1, 0);
        end else begin
          check("a_index", int'(a_if.res_index), int'(q_a[0].idx));
          check("a_color", int'(a_if.res_color), int'(q_a[0].color));
          check("a_mean", int'(a_if.res_mean), int'(q_a[0].mean));
          void'(q_a.pop_front());
        end
      end
    end
    a_pv <= a_if.res_valid;
  end

  // Monitor for the 4-pixel instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_if.res_valid && !b_pv) check("b_latency", cyc - acc_cyc[1], SUM_W + 1);
      if (b_if.res_valid && b_if.res_ready) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_record", 1, 0);
        end else begin
          check("b_index", int'(b_if.res_index), int'(q_b[0].idx));
          check("b_color", int'(b_if.res_color), int'(q_b[0].color));
          check("b_mean", int'(b_if.res_mean), int'(q_b[0].mean));
          void'(q_b.pop_front());
        end
      end
    end
    b_pv <= b_if.res_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    drive(0, 1'b0, 5'd0, 24'd0);
    drive(1, 1'b0, 5'd0, 24'd0);
    a_if.res_ready = 1'b1;
    b_if.res_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      model_clear(s);
      m_err[s] = 1'b0;
      acc_cyc[s] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(a_if.busy), 0);
    check("rst_res_valid", int'(a_if.res_valid), 0);
    check("rst_res_index", int'(a_if.res_index), 0);
    check("rst_res_color", int'(a_if.res_color), 0);
    check("rst_res_mean", int'(a_if.res_mean), 0);
    check("rst_idx_err", int'(a_if.idx_err), 0);
    rst_n = 1'b1;

    // Single saturated red image.
    for (int p = 0; p < 16; p++) send(0, 5'd7, 24'hFF0000);
    idle(0);
    drain(0);

    // R/B count tie resolves to R.
    for (int p = 0; p < 8; p++) send(0, 5'd1, 24'h100000);
    for (int p = 0; p < 8; p++) send(0, 5'd1, 24'h000020);
    idle(0);
    drain(0);

    // Back-pressure: record held, pixels dropped while busy.
    @(posedge clk); #1 a_if.res_ready = 1'b0;
    for (int p = 0; p < 16; p++) send(0, 5'd2, 24'h0000FF);
    idle(0);
    g = 0;
    while (!a_if.res_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("hold_valid_seen", int'(a_if.res_valid), 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 5'd2, 24'h0000FF);
      check("hold_busy", int'(a_if.busy), 1);
      check("hold_valid", int'(a_if.res_valid), 1);
      check("hold_index", int'(a_if.res_index), 2);
      check("hold_color", int'(a_if.res_color), 2);
      check("hold_mean", int'(a_if.res_mean), 255);
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_if.res_ready = 1'b1;
    drive(0, 1'b0, 5'd0, 24'd0);
    @(posedge clk);
    @(negedge clk);
    check("post_hs_valid", int'(a_if.res_valid), 0);
    check("post_hs_busy", int'(a_if.busy), 0);
    check("post_hs_index_kept", int'(a_if.res_index), 2);
    check("post_hs_mean_kept", int'(a_if.res_mean), 255);
    for (int p = 0; p < 16; p++) send(0, 5'd4, 24'h000010);
    idle(0);
    drain(0);

    // Reset mid-image aborts the partial image.
    for (int p = 0; p < 9; p++) send(0, 5'd9, 24'h123456);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 5'd0, 24'd0);
    model_clear(0);
    model_clear(1);
    m_err[0] = 1'b0;
    m_err[1] = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(a_if.res_valid), 0);
    check("mid_rst_busy", int'(a_if.busy), 0);
    rst_n = 1'b1;
    for (int p = 0; p < 16; p++) send(0, 5'd3, 24'h00FF00);
    idle(0);
    drain(0);
    check("idx_err_clean", int'(a_if.idx_err), 0);

    // Four-pixel instance: G dominant, mean floor(31/3).
    send(1, 5'd6, 24'h000A00);
    send(1, 5'd6, 24'h000A00);
    send(1, 5'd6, 24'h000B00);
    send(1, 5'd6, 24'h050000);
    idle(1);
    drain(1);

    // Random images on both instances.
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 16; p++) send(0, 5'(10 + i), 24'($urandom));
      idle(0);
      drain(0);
    end
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 4; p++) send(1, 5'(20 + i), 24'($urandom));
      idle(1);
      drain(1);
    end
    check("b_idx_err", int'(b_if.idx_err), int'(m_err[1]));

    // 32 back-to-back grey images; index glitch inside image 5.
    for (int img = 0; img < 32; img++) begin
      for (int p = 0; p < 16; p++) begin
        send(0, (img == 5 && p >= 8) ? 5'd6 : 5'(img), 24'h808080);
      end
    end
    idle(0);
    drain(0);
    check("idx_err_sticky", int'(a_if.idx_err), int'(m_err[0]));
    check("idx_err_set", int'(a_if.idx_err), 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
